// File: rtl/dircc_pmem_arb_pkg.sv
// Shared defaults, FSM state type and burst-length helper for the PMEM port arbiter.
// Pure declarations: no latency, no flow control.
package dircc_pmem_arb_pkg;

  localparam int DEF_ADDR_W  = 15;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_BURST_W = 4;
  localparam int MAX_BURST   = 8;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST
  } arb_state_t;

  // A burstcount of 0 still moves one beat; oversize requests are cut to MAX_BURST.
  function automatic logic [CNT_W-1:0] burst_beats(input logic [31:0] bc);
    if (bc == 32'd0) return CNT_W'(1);
    if (bc > 32'(MAX_BURST)) return CNT_W'(MAX_BURST);
    return CNT_W'(bc);
  endfunction

endpackage

// File: rtl/dircc_rr_arb2.sv
// Two-way round-robin pick: favours the requester that was not granted last.
// Combinational, zero latency; a lone requester always wins.
module dircc_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  assign grant[0] = req[0] & (~req[1] | last);
  assign grant[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/dircc_pmem_port_arbiter.sv
// Arbitrates two burst requesters onto one single-cycle memory port; beat 0 issues in the grant cycle.
// Read data returns one cycle after issue; the non-owner is held off with waitrequest for the whole burst.
module dircc_pmem_port_arbiter
  import dircc_pmem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  r0_address,
  input  logic               r0_read,
  input  logic               r0_write,
  input  logic [BURST_W-1:0] r0_burstcount,
  input  logic [DATA_W-1:0]  r0_writedata,
  input  logic [1:0]         r0_byteenable,
  output logic               r0_waitrequest,
  output logic [DATA_W-1:0]  r0_readdata,
  output logic               r0_readdatavalid,
  input  logic [ADDR_W-1:0]  r1_address,
  input  logic               r1_read,
  input  logic               r1_write,
  input  logic [BURST_W-1:0] r1_burstcount,
  input  logic [DATA_W-1:0]  r1_writedata,
  input  logic [1:0]         r1_byteenable,
  output logic               r1_waitrequest,
  output logic [DATA_W-1:0]  r1_readdata,
  output logic               r1_readdatavalid,
  output logic [ADDR_W-1:0]  mem_address,
  output logic               mem_chipselect,
  output logic               mem_write,
  output logic [DATA_W-1:0]  mem_writedata,
  output logic [1:0]         mem_byteenable,
  output logic               mem_clken,
  input  logic [DATA_W-1:0]  mem_readdata
);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_own_q, rd_own_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        req, grant, ack;

  logic               sel;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [BURST_W-1:0] sel_bc;
  logic [CNT_W-1:0]   beats;

  assign req = {r1_read | r1_write, r0_read | r0_write};

  dircc_rr_arb2 u_rr (
    .req   (req),
    .last  (last_q),
    .grant (grant)
  );

  // In IDLE the requester mux follows the arbiter so beat 0 can leave in the grant cycle.
  assign sel            = (state_q == IDLE) ? grant[1] : owner_q;
  assign sel_write      = sel ? r1_write      : r0_write;
  assign sel_addr       = sel ? r1_address    : r0_address;
  assign sel_bc         = sel ? r1_burstcount : r0_burstcount;
  assign mem_writedata  = sel ? r1_writedata  : r0_writedata;
  assign mem_byteenable = sel ? r1_byteenable : r0_byteenable;
  assign beats          = burst_beats(32'(sel_bc));

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    rd_vld_d       = 1'b0;
    rd_own_d       = rd_own_q;
    ack            = 2'b00;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = addr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          ack            = grant;
          mem_chipselect = 1'b1;
          mem_write      = sel_write;
          mem_address    = sel_addr;
          rd_vld_d       = ~sel_write;
          rd_own_d       = sel;
          owner_d        = sel;
          cnt_d          = beats - CNT_W'(1);
          addr_d         = sel_addr + ADDR_W'(1);
          if (beats == CNT_W'(1)) begin
            last_d = sel;
          end else begin
            state_d = sel_write ? WR_BURST : RD_BURST;
          end
        end
      end
      RD_BURST: begin
        mem_chipselect = 1'b1;
        rd_vld_d       = 1'b1;
        rd_own_d       = owner_q;
        addr_d         = addr_q + ADDR_W'(1);
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      WR_BURST: begin
        if (sel_write) begin
          ack            = owner_q ? 2'b10 : 2'b01;
          mem_chipselect = 1'b1;
          mem_write      = 1'b1;
          addr_d         = addr_q + ADDR_W'(1);
          cnt_d          = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Grant logic is combinational, so it must be masked while reset is held.
    if (!reset_n) begin
      ack            = 2'b00;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      rd_vld_q <= 1'b0;
      rd_own_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rd_vld_q <= rd_vld_d;
      rd_own_q <= rd_own_d;
    end
  end

  assign r0_waitrequest   = ~ack[0];
  assign r1_waitrequest   = ~ack[1];
  assign r0_readdatavalid = rd_vld_q & ~rd_own_q;
  assign r1_readdatavalid = rd_vld_q & rd_own_q;
  assign r0_readdata      = r0_readdatavalid ? mem_readdata : '0;
  assign r1_readdata      = r1_readdatavalid ? mem_readdata : '0;
  assign mem_clken        = reset_n;

endmodule

// File: tb/tb_dircc_pmem_port_arbiter.sv
// Directed and randomized bench for dircc_pmem_port_arbiter with a transaction-level memory model.
// Expected beats, addresses, data and grant order are derived from requests, not from DUT state.
module tb_dircc_pmem_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] r0_address, r1_address;
  logic          r0_read, r0_write, r1_read, r1_write;
  logic [BW-1:0] r0_burstcount, r1_burstcount;
  logic [DW-1:0] r0_writedata, r1_writedata;
  logic [1:0]    r0_byteenable, r1_byteenable;
  logic          r0_waitrequest, r1_waitrequest;
  logic [DW-1:0] r0_readdata, r1_readdata;
  logic          r0_readdatavalid, r1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic [1:0]    mem_byteenable;

  always #5 clk = ~clk;

  dircc_pmem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
    .r0_burstcount(r0_burstcount), .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable),
    .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
    .r1_burstcount(r1_burstcount), .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable),
    .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] d;
    logic [1:0]    be;
  } beat_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [DW-1:0] d;
  } rd_t;

  typedef struct packed {
    logic                n;
    logic                rd;
    logic                wr;
    logic [AW-1:0]       addr;
    logic [BW-1:0]       bc;
    logic [7:0][DW-1:0]  d;
    logic [7:0][1:0]     be;
    logic [7:0]          stall;
  } txn_t;

  beat_t iss_q[$];
  rd_t   rd0_q[$];
  rd_t   rd1_q[$];
  txn_t  exp_q[$];

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int          passed  = 0;
  int          total   = 0;
  int          failed  = 0;
  int          inv_bad = 0;
  logic [31:0] cyc     = 0;
  bit          model_last = 1'b1;

  // Memory device: registered read, byte-lane writes.
  initial for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i * 37 + 5);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        if (mem_byteenable[0]) mem[mem_address][7:0]  <= mem_writedata[7:0];
        if (mem_byteenable[1]) mem[mem_address][15:8] <= mem_writedata[15:8];
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_chipselect) iss_q.push_back({cyc, mem_address, mem_write, mem_writedata, mem_byteenable});
      if (r0_readdatavalid) rd0_q.push_back({cyc, r0_readdata});
      if (r1_readdatavalid) rd1_q.push_back({cyc, r1_readdata});
      if (!r0_waitrequest && !r1_waitrequest) inv_bad++;
      if ((!r0_waitrequest || !r1_waitrequest) && !mem_chipselect) inv_bad++;
      if (r0_readdatavalid && r1_readdatavalid) inv_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic wreq(input bit n);
    return n ? r1_waitrequest : r0_waitrequest;
  endfunction

  function automatic int model_beats(input logic [BW-1:0] bc);
    if (bc == 0) return 1;
    if (bc > 8) return 8;
    return int'(bc);
  endfunction

  task automatic set_cmd(input bit n, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] bc, input logic [DW-1:0] d, input logic [1:0] be);
    if (n) begin
      r1_read = rd; r1_write = wr; r1_address = a; r1_burstcount = bc;
      r1_writedata = d; r1_byteenable = be;
    end else begin
      r0_read = rd; r0_write = wr; r0_address = a; r0_burstcount = bc;
      r0_writedata = d; r0_byteenable = be;
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic wait_acc(input bit n, output bit ok);
    int k = 0;
    #3;
    while (wreq(n) !== 1'b0 && k < 300) begin
      @(posedge clk);
      #4;
      k++;
    end
    ok = (wreq(n) === 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input txn_t t);
    bit ok;
    int nb = model_beats(t.bc);
    set_cmd(t.n, t.rd, t.wr, t.addr, t.bc, t.d[0], t.be[0]);
    wait_acc(t.n, ok);
    chk("grant_wait", 32'(ok), 32'd1);
    if (t.wr) begin
      for (int i = 1; i < nb; i++) begin
        if (t.stall[i]) begin
          set_cmd(t.n, 1'b0, 1'b0, t.addr, t.bc, t.d[i], t.be[i]);
          step(1);
        end
        set_cmd(t.n, 1'b0, 1'b1, t.addr, t.bc, t.d[i], t.be[i]);
        wait_acc(t.n, ok);
        chk("beat_wait", 32'(ok), 32'd1);
      end
    end
    set_cmd(t.n, 1'b0, 1'b0, t.addr, t.bc, '0, '0);
  endtask

  function automatic txn_t mk(input bit n, input bit rd, input bit wr,
                              input logic [AW-1:0] a, input logic [BW-1:0] bc);
    txn_t t = '0;
    t.n = n; t.rd = rd; t.wr = wr; t.addr = a; t.bc = bc;
    return t;
  endfunction

  function automatic txn_t rand_txn(input bit n);
    txn_t t = '0;
    t.n    = n;
    t.wr   = 1'($urandom_range(0, 1));
    t.rd   = t.wr ? 1'($urandom_range(0, 1)) : 1'b1;
    t.addr = ($urandom_range(0, 3) == 0) ? AW'(15'h7FF8 + AW'($urandom_range(0, 7))) : AW'($urandom);
    t.bc   = BW'($urandom_range(0, 15));
    for (int i = 0; i < 8; i++) begin
      t.d[i]  = DW'($urandom);
      t.be[i] = 2'($urandom);
    end
    if (t.wr) t.stall = 8'($urandom) & 8'hFE;
    return t;
  endfunction

  // Walks the expected transactions in grant order against observed beats and returns.
  task automatic check_exp(input string tag);
    txn_t          t;
    beat_t         b;
    rd_t           r;
    bit            got;
    int            nb;
    logic [AW-1:0] ea;
    logic [31:0]   prev;
    prev = 0;
    while (exp_q.size() > 0) begin
      t  = exp_q.pop_front();
      nb = model_beats(t.bc);
      for (int i = 0; i < nb; i++) begin
        ea = t.addr + AW'(i);
        chk({tag, "_beat_present"}, 32'(iss_q.size() != 0), 32'd1);
        if (iss_q.size() == 0) break;
        b = iss_q.pop_front();
        chk({tag, "_addr"}, 32'(b.addr), 32'(ea));
        chk({tag, "_is_write"}, 32'(b.wr), 32'(t.wr));
        if (i > 0) chk({tag, "_beat_gap"}, b.cyc - prev, 32'd1 + 32'(t.wr & t.stall[i]));
        prev = b.cyc;
        if (t.wr) begin
          chk({tag, "_wdata"}, 32'(b.d), 32'(t.d[i]));
          chk({tag, "_be"}, 32'(b.be), 32'(t.be[i]));
          if (t.be[i][0]) ref_mem[ea][7:0]  = t.d[i][7:0];
          if (t.be[i][1]) ref_mem[ea][15:8] = t.d[i][15:8];
        end else begin
          got = t.n ? (rd1_q.size() != 0) : (rd0_q.size() != 0);
          chk({tag, "_rd_present"}, 32'(got), 32'd1);
          if (got) begin
            r = t.n ? rd1_q.pop_front() : rd0_q.pop_front();
            chk({tag, "_rdata"}, 32'(r.d), 32'(ref_mem[ea]));
            chk({tag, "_rd_latency"}, r.cyc, b.cyc + 32'd1);
          end
        end
      end
    end
    chk({tag, "_extra_beats"}, 32'(iss_q.size()), 32'd0);
    chk({tag, "_extra_rd0"}, 32'(rd0_q.size()), 32'd0);
    chk({tag, "_extra_rd1"}, 32'(rd1_q.size()), 32'd0);
    iss_q.delete();
    rd0_q.delete();
    rd1_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs"}, 32'(mem_chipselect), 32'd0);
    chk({tag, "_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_clken"}, 32'(mem_clken), 32'd0);
    chk({tag, "_wreq0"}, 32'(r0_waitrequest), 32'd1);
    chk({tag, "_wreq1"}, 32'(r1_waitrequest), 32'd1);
    chk({tag, "_rdv0"}, 32'(r0_readdatavalid), 32'd0);
    chk({tag, "_rdv1"}, 32'(r1_readdatavalid), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    #3;
    chk({tag, "_cs"}, 32'(mem_chipselect), 32'd0);
    chk({tag, "_wreq0"}, 32'(r0_waitrequest), 32'd1);
    chk({tag, "_wreq1"}, 32'(r1_waitrequest), 32'd1);
    chk({tag, "_clken"}, 32'(mem_clken), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    txn_t t0, t1, t2;
    bit   ok;
    bit   pair;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = DW'(i * 37 + 5);
    reset_n = 1'b1;
    set_cmd(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_cmd(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    #1;
    reset_n = 1'b0;
    r0_read = 1'b1;
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    step(2);
    r0_read = 1'b0;
    reset_n = 1'b1;
    step(1);
    chk_idle("idle_after_reset");

    // Simultaneous single reads right after reset: r0, then r1, then r0 re-requesting loses to r1's turn.
    t0 = mk(1'b0, 1'b1, 1'b0, 15'h0020, 4'd1);
    t1 = mk(1'b1, 1'b1, 1'b0, 15'h0030, 4'd1);
    t2 = mk(1'b0, 1'b1, 1'b0, 15'h0021, 4'd1);
    fork
      begin drive(t0); drive(t2); end
      drive(t1);
    join
    exp_q.push_back(t0); exp_q.push_back(t1); exp_q.push_back(t2);
    model_last = 1'b0;
    step(4);
    check_exp("rr_order");

    // Four-beat read from r0.
    t0 = mk(1'b0, 1'b1, 1'b0, 15'h0010, 4'd4);
    drive(t0);
    exp_q.push_back(t0);
    model_last = 1'b0;
    step(8);
    check_exp("rd_burst4");

    // Wrapping write burst from r1 with one stall cycle, then read it back through r0.
    t1 = mk(1'b1, 1'b0, 1'b1, 15'h7FFE, 4'd3);
    t1.d[0] = 16'h00A1; t1.d[1] = 16'h00A2; t1.d[2] = 16'h00A3;
    t1.be[0] = 2'b11; t1.be[1] = 2'b11; t1.be[2] = 2'b11;
    t1.stall[1] = 1'b1;
    drive(t1);
    t0 = mk(1'b0, 1'b1, 1'b0, 15'h7FFE, 4'd3);
    drive(t0);
    exp_q.push_back(t1); exp_q.push_back(t0);
    model_last = 1'b0;
    step(8);
    check_exp("wr_wrap");

    // Read and write together with burstcount 0: one write beat only.
    t0 = mk(1'b0, 1'b1, 1'b1, 15'h0040, 4'd0);
    t0.d[0] = 16'h5A5A; t0.be[0] = 2'b01;
    drive(t0);
    exp_q.push_back(t0);
    model_last = 1'b0;
    step(4);
    check_exp("rw_bc0");

    // r1 arrives mid-way through an eight-beat r0 read and must wait it out.
    t0 = mk(1'b0, 1'b1, 1'b0, 15'h0200, 4'd8);
    t1 = mk(1'b1, 1'b1, 1'b0, 15'h0300, 4'd1);
    fork
      drive(t0);
      begin step(3); drive(t1); end
    join
    step(12);
    chk("r1_beats_seen", 32'(iss_q.size() >= 9), 32'd1);
    if (iss_q.size() >= 9) chk("r1_grant_gap_ok", 32'((iss_q[8].cyc - iss_q[7].cyc) <= 2), 32'd1);
    exp_q.push_back(t0); exp_q.push_back(t1);
    model_last = 1'b1;
    check_exp("hold_off");

    // Reset in the third beat of an eight-beat read, with r1 also requesting.
    set_cmd(1'b0, 1'b1, 1'b0, 15'h0100, 4'd8, '0, '0);
    wait_acc(1'b0, ok);
    chk("abort_grant", 32'(ok), 32'd1);
    set_cmd(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    step(1);
    set_cmd(1'b1, 1'b1, 1'b0, 15'h0400, 4'd1, '0, '0);
    reset_n = 1'b0;
    #2;
    chk_reset_outputs("abort");
    set_cmd(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    step(2);
    reset_n = 1'b1;
    step(12);
    chk("abort_beats", 32'(iss_q.size()), 32'd2);
    chk("abort_returns", 32'(rd0_q.size() + rd1_q.size()), 32'd1);
    iss_q.delete(); rd0_q.delete(); rd1_q.delete();
    model_last = 1'b1;
    chk_idle("idle_after_abort");

    // Randomized traffic: lone requests and simultaneous pairs.
    for (int it = 0; it < 40; it++) begin
      pair = ($urandom_range(0, 2) == 0);
      t0 = rand_txn(1'($urandom_range(0, 1)));
      if (pair) begin
        t1 = rand_txn(~t0.n);
        fork
          drive(t0);
          drive(t1);
        join
        if (t0.n == !model_last) begin
          exp_q.push_back(t0); exp_q.push_back(t1); model_last = t1.n;
        end else begin
          exp_q.push_back(t1); exp_q.push_back(t0); model_last = t0.n;
        end
      end else begin
        drive(t0);
        exp_q.push_back(t0);
        model_last = t0.n;
      end
      step(12);
      check_exp("rnd");
    end

    chk("invariants", 32'(inv_bad), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dircc_pmem_port_arbiter.md
DIRCC_PMEM_PORT_ARBITER -- requirements
Module: dircc_pmem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word address width of the shared 16-bit memory port.
REQ-002 SHALL have parameter DATA_W, default 16, data width of the shared port.
REQ-003 SHALL have parameter BURST_W, default 4, burstcount width (max burst 8).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 rN_address  in  ADDR_W  requester N (N=0,1) start word address.
REQ-007 rN_read / rN_write  in  1 each  requester N command strobes.
REQ-008 rN_burstcount  in  BURST_W  beats requested; 0 treated as 1, values >8 clamped to 8.
REQ-009 rN_writedata  in  DATA_W; rN_byteenable  in  2  write beat data/lanes.
REQ-010 rN_waitrequest  out  1  high = command/beat not accepted this cycle.
REQ-011 rN_readdata  out  DATA_W; rN_readdatavalid  out  1  read return to requester N.
REQ-012 mem_address  out  ADDR_W; mem_chipselect, mem_write  out  1 each  to memory port.
REQ-013 mem_writedata  out  DATA_W; mem_byteenable  out  2; mem_clken  out  1 (held 1 outside reset).
REQ-014 mem_readdata  in  DATA_W  memory output, valid exactly 1 cycle after address issued.

Function
REQ-015 FSM states SHALL be IDLE, RD_BURST, WR_BURST.
REQ-016 IDLE: with no request, mem_chipselect=0, both waitrequest=1.
REQ-017 IDLE with requests: grant the requester not granted last; after reset r0 has priority; single requester granted immediately.
REQ-018 Grant cycle SHALL drop the owner's waitrequest, issue beat 0 at rN_address, and latch remaining beat count and next address.
REQ-019 Same-cycle read+write from one requester SHALL be executed as write.
REQ-020 RD_BURST: issue one read beat per cycle at incrementing address, no owner handshake, until count reaches 0, then IDLE.
REQ-021 WR_BURST: owner waitrequest low only while owner asserts rN_write; each accepted beat issues a write at next address; count 0 -> IDLE.
REQ-022 Address increment SHALL wrap 2^ADDR_W-1 -> 0.
REQ-023 Non-owner waitrequest SHALL stay 1 for the entire burst; its request is held pending.
REQ-024 Each read beat's owner SHALL be registered; rN_readdatavalid pulses for that owner exactly 1 cycle after issue with rN_readdata=mem_readdata.
REQ-025 rN_readdata SHALL be driven only for the owner; the other requester's readdatavalid stays 0.
REQ-026 Last beat of a burst and a new grant in the next cycle SHALL be allowed (no idle bubble required, one IDLE cycle permitted).
REQ-027 Round-robin pointer SHALL update only when a burst completes.

Reset
REQ-028 On reset_n low: state IDLE, mem_chipselect=0, mem_write=0, mem_clken=0, both waitrequest=1, both readdatavalid=0, pointer favours r0.
REQ-029 Reset mid-burst SHALL abort immediately; in-flight read returns SHALL be discarded.

Structure
REQ-030 Package dircc_pmem_arb_pkg SHALL hold ADDR_W/DATA_W/BURST_W defaults, MAX_BURST=8 and the state enum.
REQ-031 Two-way round-robin decision SHALL be sub-module dircc_rr_arb2 (req[1:0], last, grant[1:0]).

Verification
REQ-032 r0 read addr 0x0010 burst 4, r1 idle -> mem reads 0x0010..0x0013 consecutive cycles; r0_readdatavalid 4 pulses, each 1 cycle after issue.
REQ-033 r0 and r1 read burst 1 same cycle after reset -> r0 served first, r1 next; repeat -> r1 now first.
REQ-034 r1 write burst 3 at 0x7FFE, data 0xA1,0xA2,0xA3, r1_write dropped one cycle mid-burst -> writes 0x7FFE,0x7FFF,0x0000; stall cycle mem_chipselect=0.
REQ-035 r0 write+read same cycle, burstcount 0 -> single write beat, no readdatavalid.
REQ-036 reset_n low during 3rd beat of 8-beat read -> all outputs at reset values that cycle; no further readdatavalid.
REQ-037 r1 requests during r0 8-beat burst -> r1_waitrequest=1 throughout, r1 granted within 2 cycles of r0 last beat.
